// File: rtl/response_tree_l2.sv
// response_tree_l2: response-side counterpart of the L2 request arbitration tree.
// Snoops accepted requests, carries the winner's decoded master select through a
// MEM_LATENCY-deep pipeline and raises that master's r_valid as the bank returns data.
// Optional feature macro: RESP_REG_EN registers data_r_valid_o/data_r_rdata_o, adding one
// cycle of latency; that output slot is also counted in inflight_o.
module response_tree_l2 #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned N_MASTER    = 16,
    parameter int unsigned ID_WIDTH    = N_MASTER,
    parameter int unsigned MEM_LATENCY = 1,
    localparam int unsigned CNT_WIDTH  = $clog2(MEM_LATENCY + 2)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           data_req_i,
    input  logic                           data_gnt_i,
    input  logic                           data_wen_i,
    input  logic [ID_WIDTH-1:0]            data_ID_i,
    input  logic [DATA_WIDTH-1:0]          data_r_rdata_i,
    output logic [N_MASTER-1:0]            data_r_valid_o,
    output logic [N_MASTER*DATA_WIDTH-1:0] data_r_rdata_o,
    output logic [CNT_WIDTH-1:0]           inflight_o,
    output logic                           id_err_o
);

    localparam int unsigned LAST = MEM_LATENCY - 1;

    logic                 acc;
    logic [ID_WIDTH-1:0]  id_low;
    logic                 id_bad;
    logic [MEM_LATENCY-1:0] vld_q;
    logic [N_MASTER-1:0]  sel_q [MEM_LATENCY];
    logic [N_MASTER-1:0]  sel_last;
    logic                 drain;
    logic [CNT_WIDTH-1:0] inflight_q, inflight_d;
    logic                 id_err_q;
    logic                 unused_wen;

    assign acc = data_req_i & data_gnt_i;

    // Lowest set bit wins for a multi-hot ID; a zero ID decodes to no master at all.
    assign id_low = data_ID_i & (~data_ID_i + ID_WIDTH'(1));
    assign id_bad = (data_ID_i == '0) || ((data_ID_i & (data_ID_i - ID_WIDTH'(1))) != '0);

    // Reads and writes get identical responses, so the direction is not tracked.
    assign unused_wen = data_wen_i;

    assign sel_last = vld_q[LAST] ? sel_q[LAST] : '0;

    // Slot-valid shift register; reset drops every in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= acc;
            for (int s = 1; s < int'(MEM_LATENCY); s++) begin
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    // Master-select payload; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        sel_q[0] <= id_low;
        for (int s = 1; s < int'(MEM_LATENCY); s++) begin
            sel_q[s] <= sel_q[s-1];
        end
    end

`ifdef RESP_REG_EN
    logic [N_MASTER-1:0]   r_valid_q;
    logic [DATA_WIDTH-1:0] r_rdata_q;
    logic                  out_slot_q;

    // Output stage: a delivered slot lives here one more cycle, zero-ID slots included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q  <= '0;
            r_rdata_q  <= '0;
            out_slot_q <= 1'b0;
        end else begin
            r_valid_q  <= sel_last;
            r_rdata_q  <= data_r_rdata_i;
            out_slot_q <= vld_q[LAST];
        end
    end

    assign data_r_valid_o = r_valid_q;
    assign data_r_rdata_o = {N_MASTER{r_rdata_q}};
    assign drain          = out_slot_q;
`else
    assign data_r_valid_o = sel_last;
    assign data_r_rdata_o = {N_MASTER{data_r_rdata_i}};
    assign drain          = vld_q[LAST];
`endif

    // In-flight count: +1 per accept, -1 per slot leaving the last stage.
    always_comb begin
        inflight_d = inflight_q;
        if (acc && !drain) begin
            inflight_d = inflight_q + CNT_WIDTH'(1);
        end else if (!acc && drain) begin
            inflight_d = inflight_q - CNT_WIDTH'(1);
        end
    end

    // Counter and sticky ID-error flag; only reset clears the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            id_err_q   <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (acc && id_bad) begin
                id_err_q <= 1'b1;
            end
        end
    end

    assign inflight_o = inflight_q;
    assign id_err_o   = id_err_q;

endmodule

// File: tb/tb_response_tree_l2.sv
// Bench for response_tree_l2: three instances (MEM_LATENCY 1, 2, 3, N_MASTER 4) share the
// stimulus; a per-instance scoreboard queue holds expected responses pushed at accept time.
module tb_response_tree_l2;

    localparam int NM = 4;
    localparam int DW = 64;
    localparam int NI = 3;
`ifdef RESP_REG_EN
    localparam int REG = 1;
`else
    localparam int REG = 0;
`endif

    typedef struct {
        int            last;
        logic [NM-1:0] sel;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          gnt = 1'b0;
    logic          wen = 1'b1;
    logic [NM-1:0] id  = '0;
    logic [DW-1:0] rdata_in;

    logic [NM-1:0]    rv  [NI];
    logic [NM*DW-1:0] rd  [NI];
    logic [2:0]       inf [NI];
    logic             err [NI];

    exp_t sb [NI][$];
    logic err_m [NI];
    int   edges   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned LAT = g + 1;
        logic [$clog2(LAT + 2)-1:0] inf_w;

        response_tree_l2 #(
            .DATA_WIDTH (DW),
            .N_MASTER   (NM),
            .ID_WIDTH   (NM),
            .MEM_LATENCY(LAT)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .data_req_i    (req),
            .data_gnt_i    (gnt),
            .data_wen_i    (wen),
            .data_ID_i     (id),
            .data_r_rdata_i(rdata_in),
            .data_r_valid_o(rv[g]),
            .data_r_rdata_o(rd[g]),
            .inflight_o    (inf_w),
            .id_err_o      (err[g])
        );

        assign inf[g] = 3'(inf_w);
    end

    // Bank data pattern: a distinct word for every cycle.
    function automatic logic [DW-1:0] f(int e);
        return {32'(e) ^ 32'hA5A5_A5A5, 32'(e * 7 + 3)};
    endfunction

    // One clock: update the scoreboard from the sampled inputs, then pop and compare.
    task automatic advance();
        exp_t          e;
        logic [NM-1:0] exp_rv;
        @(posedge clk);
        edges++;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                sb[k].delete();
                err_m[k] = 1'b0;
            end else if (req && gnt) begin
                if (id == '0 || (id & (id - 1'b1)) != '0) err_m[k] = 1'b1;
                e.sel = '0;
                for (int j = NM - 1; j >= 0; j--) begin
                    if (id[j]) e.sel = NM'(1) << j;
                end
                e.last = edges + k + REG;
                e.data = f(edges + k);
                sb[k].push_back(e);
            end
        end
        #1 rdata_in = f(edges);
        #1;
        for (int k = 0; k < NI; k++) begin
            while (sb[k].size() > 0 && sb[k][0].last < edges) void'(sb[k].pop_front());
            exp_rv = '0;
            if (sb[k].size() > 0 && sb[k][0].last == edges) exp_rv = sb[k][0].sel;
            n_tests++;
            if (rv[k] !== exp_rv) begin
                n_fail++;
                $display("FAIL sb_rvalid lat%0d edge%0d: got %b want %b",
                         k + 1, edges, rv[k], exp_rv);
            end
            n_tests++;
            if (inf[k] !== 3'(sb[k].size())) begin
                n_fail++;
                $display("FAIL sb_inflight lat%0d edge%0d: got %0d want %0d",
                         k + 1, edges, inf[k], sb[k].size());
            end
            n_tests++;
            if (err[k] !== err_m[k]) begin
                n_fail++;
                $display("FAIL sb_id_err lat%0d edge%0d: got %b want %b",
                         k + 1, edges, err[k], err_m[k]);
            end
            if (exp_rv != '0) begin
                for (int j = 0; j < NM; j++) begin
                    n_tests++;
                    if (rd[k][j*DW +: DW] !== sb[k][0].data) begin
                        n_fail++;
                        $display("FAIL sb_rdata lat%0d lane%0d edge%0d: got %h want %h",
                                 k + 1, j, edges, rd[k][j*DW +: DW], sb[k][0].data);
                    end
                end
            end
        end
    endtask

    task automatic idle(int n);
        req = 1'b0;
        gnt = 1'b0;
        for (int i = 0; i < n; i++) advance();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        advance();
        advance();
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (rv[k] !== '0 || inf[k] !== '0 || err[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset lat%0d: got rv=%b inf=%0d err=%b want 0/0/0",
                         k + 1, rv[k], inf[k], err[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        id  = 4'b0100;
        req = 1'b1;
        gnt = 1'b1;
        wen = 1'b1;
        advance();
        n_tests++;
        if (inf[0] !== 3'd1) begin
            n_fail++;
            $display("FAIL single_inflight: got %0d want 1", inf[0]);
        end
        idle(6);
    endtask

    task automatic test_back_to_back();
        logic [NM-1:0] ids [4];
        logic [2:0]    peak;
        ids  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        peak = '0;
        for (int i = 0; i < 4; i++) begin
            id  = ids[i];
            req = 1'b1;
            gnt = 1'b1;
            wen = i[0];
            advance();
            if (inf[2] > peak) peak = inf[2];
        end
        req = 1'b0;
        gnt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            advance();
            if (inf[2] > peak) peak = inf[2];
        end
        n_tests++;
        if (peak !== 3'(3 + REG)) begin
            n_fail++;
            $display("FAIL b2b_peak_inflight: got %0d want %0d", peak, 3 + REG);
        end
    endtask

    task automatic test_no_grant();
        id  = 4'b0001;
        req = 1'b1;
        gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            advance();
            n_tests++;
            if (rv[2] !== '0 || inf[2] !== '0) begin
                n_fail++;
                $display("FAIL no_grant cyc%0d: got rv=%b inf=%0d want 0/0", i, rv[2], inf[2]);
            end
        end
        idle(1);
    endtask

    task automatic test_id_err();
        id  = 4'b0110;
        req = 1'b1;
        gnt = 1'b1;
        advance();
        idle(5);
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (err[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL id_err_multihot lat%0d: got %b want 1", k + 1, err[k]);
            end
        end
        id  = 4'b0000;
        req = 1'b1;
        gnt = 1'b1;
        advance();
        idle(5);
        n_tests++;
        if (err[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL id_err_zero_held: got %b want 1", err[1]);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        id  = 4'b0001;
        req = 1'b1;
        gnt = 1'b1;
        advance();
        id = 4'b0010;
        advance();
        req = 1'b0;
        gnt = 1'b0;
        rst = 1'b1;
        advance();
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (rv[k] !== '0 || inf[k] !== '0 || err[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid lat%0d: got rv=%b inf=%0d err=%b want 0/0/0",
                         k + 1, rv[k], inf[k], err[k]);
            end
        end
        rst = 1'b0;
        idle(6);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            req = 1'($urandom_range(0, 3) != 0);
            gnt = 1'($urandom_range(0, 3) != 0);
            wen = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) id = 4'($urandom);
            else id = 4'(1 << $urandom_range(0, 3));
            advance();
        end
        idle(6);
    endtask

    initial begin
        rdata_in = f(0);
        for (int k = 0; k < NI; k++) err_m[k] = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_no_grant();
        test_id_err();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
